// File: rtl/rgb_led_arbiter.sv
// Frame-synchronous fixed-priority owner of the RGB LED plus PWM generation for SB_RGBA_DRV.
// Optional macro RGB_ARB_GAMMA_EN squares each latched colour channel (gamma approximation).
module rgb_led_arbiter #(
  parameter int unsigned NUM_REQ      = 4,
  parameter int unsigned PWM_BITS     = 8,
  parameter int unsigned BLINK_CYCLES = 6_000_000
) (
  input  logic                            hw_clk,
  input  logic                            rst_n,
  input  logic [NUM_REQ-1:0]              req,
  input  logic [NUM_REQ*3*PWM_BITS-1:0]   color,
  input  logic [NUM_REQ-1:0]              blink,
  output logic [NUM_REQ-1:0]              gnt,
  output logic                            pwm_red,
  output logic                            pwm_green,
  output logic                            pwm_blue,
  output logic                            led_en
);

  localparam int unsigned BC_W = $clog2(BLINK_CYCLES);
  localparam logic [PWM_BITS-1:0] CNT_MAX = '1;
  localparam logic [BC_W-1:0]     BC_LAST = BC_W'(BLINK_CYCLES - 1);

  typedef enum logic {S_IDLE, S_ACTIVE} state_t;

  state_t                r_state;
  logic [PWM_BITS-1:0]   r_cnt;
  logic [BC_W-1:0]       r_bcnt;
  logic                  r_phase_on;
  logic [NUM_REQ-1:0]    r_gnt;
  logic                  r_led_en;
  logic [PWM_BITS-1:0]   r_duty_r;
  logic [PWM_BITS-1:0]   r_duty_g;
  logic [PWM_BITS-1:0]   r_duty_b;
  logic                  r_blink_l;
  logic                  r_pwm_r;
  logic                  r_pwm_g;
  logic                  r_pwm_b;

  logic [NUM_REQ-1:0]    w_win_oh;
  logic                  w_win_any;
  logic [3*PWM_BITS-1:0] w_win_col;
  logic                  w_win_blink;
  logic                  w_pwm_en;

  function automatic logic [PWM_BITS-1:0] f_duty(input logic [PWM_BITS-1:0] c);
`ifdef RGB_ARB_GAMMA_EN
    logic [2*PWM_BITS-1:0] sq;
    sq = {{PWM_BITS{1'b0}}, c} * {{PWM_BITS{1'b0}}, c};
    return sq[2*PWM_BITS-1:PWM_BITS];
`else
    return c;
`endif
  endfunction

  // Lowest set index wins; its colour slice and blink bit ride along.
  always_comb begin
    w_win_oh    = '0;
    w_win_any   = 1'b0;
    w_win_col   = '0;
    w_win_blink = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (req[i] && !w_win_any) begin
        w_win_any   = 1'b1;
        w_win_oh[i] = 1'b1;
        w_win_col   = color[i*3*PWM_BITS +: 3*PWM_BITS];
        w_win_blink = blink[i];
      end
    end
  end

  assign w_pwm_en = (r_state == S_ACTIVE) && (!r_blink_l || r_phase_on);

  always_ff @(posedge hw_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_bcnt     <= '0;
      r_phase_on <= 1'b1;
      r_gnt      <= '0;
      r_led_en   <= 1'b0;
      r_duty_r   <= '0;
      r_duty_g   <= '0;
      r_duty_b   <= '0;
      r_blink_l  <= 1'b0;
      r_pwm_r    <= 1'b0;
      r_pwm_g    <= 1'b0;
      r_pwm_b    <= 1'b0;
    end else begin
      r_cnt   <= r_cnt + 1'b1;
      r_pwm_r <= w_pwm_en && (r_cnt < r_duty_r);
      r_pwm_g <= w_pwm_en && (r_cnt < r_duty_g);
      r_pwm_b <= w_pwm_en && (r_cnt < r_duty_b);

      if (r_state == S_ACTIVE) begin
        if (r_bcnt == BC_LAST) begin
          r_bcnt     <= '0;
          r_phase_on <= ~r_phase_on;
        end else begin
          r_bcnt <= r_bcnt + 1'b1;
        end
      end

      if (r_cnt == CNT_MAX) begin
        if (!w_win_any) begin
          r_state  <= S_IDLE;
          r_gnt    <= '0;
          r_led_en <= 1'b0;
        end else begin
          r_state   <= S_ACTIVE;
          r_gnt     <= w_win_oh;
          r_led_en  <= 1'b1;
          r_duty_r  <= f_duty(w_win_col[3*PWM_BITS-1 -: PWM_BITS]);
          r_duty_g  <= f_duty(w_win_col[2*PWM_BITS-1 -: PWM_BITS]);
          r_duty_b  <= f_duty(w_win_col[PWM_BITS-1:0]);
          r_blink_l <= w_win_blink;
          // A new owner (or leaving IDLE, where gnt is zero) restarts blinking; a re-win keeps it running.
          if (w_win_oh != r_gnt) begin
            r_bcnt     <= '0;
            r_phase_on <= 1'b1;
          end
        end
      end
    end
  end

  assign gnt       = r_gnt;
  assign led_en    = r_led_en;
  assign pwm_red   = r_pwm_r;
  assign pwm_green = r_pwm_g;
  assign pwm_blue  = r_pwm_b;

endmodule

// File: tb/tb_rgb_led_arbiter.sv
// Directed bench for rgb_led_arbiter with a per-cycle behavioural model (frame/elapsed-time arithmetic).
module tb_rgb_led_arbiter;

  localparam int NR = 4;
  localparam int PB = 4;
  localparam int BC = 64;
  localparam int FR = 16;

`ifdef RGB_ARB_GAMMA_EN
  localparam int S2R = 1, S2G = 0, S2B = 14;
  localparam int S3R = 0, S3G = 5, S3B = 0;
  localparam int S5ON = 56, S5RS = 14;
  localparam int S6R = 0, S6G = 0, S6B = 0;
`else
  localparam int S2R = 4, S2G = 0, S2B = 15;
  localparam int S3R = 2, S3G = 9, S3B = 0;
  localparam int S5ON = 60, S5RS = 15;
  localparam int S6R = 1, S6G = 2, S6B = 3;
`endif

  logic               hw_clk = 1'b0;
  logic               rst_n  = 1'b0;
  logic [NR-1:0]      req    = '0;
  logic [NR*3*PB-1:0] color  = '0;
  logic [NR-1:0]      blink  = '0;
  logic [NR-1:0]      gnt;
  logic               pwm_red, pwm_green, pwm_blue, led_en;

  int n_pass = 0;
  int n_tot  = 0;

  rgb_led_arbiter #(.NUM_REQ(NR), .PWM_BITS(PB), .BLINK_CYCLES(BC)) dut (
    .hw_clk(hw_clk), .rst_n(rst_n), .req(req), .color(color), .blink(blink),
    .gnt(gnt), .pwm_red(pwm_red), .pwm_green(pwm_green), .pwm_blue(pwm_blue), .led_en(led_en)
  );

  always #5 hw_clk = ~hw_clk;

  task automatic check(input string nm, input int act, input int exp);
    n_tot++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
  endtask

  function automatic int gam(input int c);
`ifdef RGB_ARB_GAMMA_EN
    return (c * c) >> PB;
`else
    return c;
`endif
  endfunction

  // Model: owner index (-1 idle), edges since reset release, edge at which current ownership began.
  int m_owner = -1, m_edges = 0, m_start = 0;
  int m_dr = 0, m_dg = 0, m_db = 0;
  bit m_blink = 0;
  int e_r = 0, e_g = 0, e_b = 0, e_gnt = 0, e_led = 0;

  always @(posedge hw_clk) begin
    if (!rst_n) begin
      m_owner = -1; m_edges = 0; m_start = 0;
      m_dr = 0; m_dg = 0; m_db = 0; m_blink = 0;
      e_r = 0; e_g = 0; e_b = 0;
    end else begin
      int pos, win;
      bit on;
      pos = m_edges % FR;
      on  = (m_owner >= 0) && (!m_blink || (((m_edges - m_start) / BC) % 2 == 0));
      e_r = (on && pos < m_dr) ? 1 : 0;
      e_g = (on && pos < m_dg) ? 1 : 0;
      e_b = (on && pos < m_db) ? 1 : 0;
      if (pos == FR - 1) begin
        win = -1;
        for (int i = NR - 1; i >= 0; i--) if (req[i]) win = i;
        if (win < 0) m_owner = -1;
        else begin
          if (win != m_owner) m_start = m_edges + 1;
          m_owner = win;
          m_dr = gam(int'(color[win*12+8 +: 4]));
          m_dg = gam(int'(color[win*12+4 +: 4]));
          m_db = gam(int'(color[win*12   +: 4]));
          m_blink = blink[win];
        end
      end
      m_edges++;
    end
    e_gnt = (m_owner >= 0) ? (1 << m_owner) : 0;
    e_led = (m_owner >= 0) ? 1 : 0;
    #1;
    check("gnt", int'(gnt), e_gnt);
    check("led_en", int'(led_en), e_led);
    check("pwm_red", int'(pwm_red), e_r);
    check("pwm_green", int'(pwm_green), e_g);
    check("pwm_blue", int'(pwm_blue), e_b);
  end

  task automatic set_col(input int i, input logic [3:0] r, input logic [3:0] g, input logic [3:0] b);
    color[i*12 +: 12] = {r, g, b};
  endtask

  task automatic wait_pos(input int p);
    int k = 0;
    while ((m_edges % FR) != p && k < 40) begin
      @(negedge hw_clk);
      k++;
    end
    check("wait_pos", m_edges % FR, p);
  endtask

  task automatic count(input int n, output int r, output int g, output int b);
    r = 0; g = 0; b = 0;
    repeat (n) begin
      @(negedge hw_clk);
      r += int'(pwm_red); g += int'(pwm_green); b += int'(pwm_blue);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not end, passed %0d of %0d", n_pass, n_tot);
    $fatal(1);
  end

  initial begin
    int r, g, b;
    // Reset and idle
    repeat (5) @(negedge hw_clk);
    check("rst_gnt", int'(gnt), 0);
    check("rst_led", int'(led_en), 0);
    rst_n = 1'b1;
    count(100, r, g, b);
    check("idle_pwm_sum", r + g + b, 0);
    check("idle_gnt", int'(gnt), 0);

    // Single owner
    set_col(2, 4'd4, 4'd0, 4'd15);
    req[2] = 1'b1;
    @(negedge hw_clk);
    wait_pos(0);
    check("single_gnt", int'(gnt), 4);
    check("single_led", int'(led_en), 1);
    count(FR, r, g, b);
    check("single_r", r, S2R);
    check("single_g", g, S2G);
    check("single_b", b, S2B);

    // Priority request mid-frame waits for the boundary
    wait_pos(5);
    set_col(0, 4'd2, 4'd9, 4'd0);
    req[0] = 1'b1;
    wait_pos(10);
    check("nopreempt_gnt", int'(gnt), 4);
    wait_pos(0);
    check("preempt_gnt", int'(gnt), 1);
    count(FR, r, g, b);
    check("prio_r", r, S3R);
    check("prio_g", g, S3G);
    check("prio_b", b, S3B);

    // Mid-frame colour change and release; old duty finishes the frame
    wait_pos(0);
    r = 0; g = 0; b = 0;
    for (int i = 0; i < FR; i++) begin
      @(negedge hw_clk);
      r += int'(pwm_red); g += int'(pwm_green); b += int'(pwm_blue);
      if (m_edges % FR == 3) set_col(0, 4'd15, 4'd15, 4'd15);
      if (m_edges % FR == 7) req = '0;
    end
    check("hold_r", r, S3R);
    check("hold_g", g, S3G);
    check("hold_b", b, S3B);
    check("release_gnt", int'(gnt), 0);
    check("release_led", int'(led_en), 0);
    count(20, r, g, b);
    check("release_pwm_sum", r + g + b, 0);

    // Blink, then owner change restarts the phase at ON
    set_col(1, 4'd15, 4'd0, 4'd0);
    blink[1] = 1'b1;
    req[1] = 1'b1;
    @(negedge hw_clk);
    wait_pos(0);
    check("blink_gnt", int'(gnt), 2);
    count(64, r, g, b);
    check("blink_on_r", r, S5ON);
    count(32, r, g, b);
    check("blink_off_r", r, 0);
    set_col(0, 4'd15, 4'd0, 4'd0);
    blink[0] = 1'b1;
    req[0] = 1'b1;
    count(FR, r, g, b);
    check("blink_off2_r", r, 0);
    check("blink_chg_gnt", int'(gnt), 1);
    count(FR, r, g, b);
    check("blink_restart_r", r, S5RS);

    // Asynchronous reset mid-frame
    wait_pos(5);
    check("pre_rst_red", int'(pwm_red), 1);
    rst_n = 1'b0;
    #1;
    check("arst_gnt", int'(gnt), 0);
    check("arst_led", int'(led_en), 0);
    check("arst_pwm", int'(pwm_red) + int'(pwm_green) + int'(pwm_blue), 0);
    req = 4'b1000;
    blink = '0;
    set_col(3, 4'd1, 4'd2, 4'd3);
    repeat (3) @(negedge hw_clk);
    rst_n = 1'b1;
    repeat (15) @(negedge hw_clk);
    check("post_rst_wait_gnt", int'(gnt), 0);
    @(negedge hw_clk);
    check("post_rst_gnt", int'(gnt), 8);
    count(FR, r, g, b);
    check("post_rst_r", r, S6R);
    check("post_rst_g", g, S6G);
    check("post_rst_b", b, S6B);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

// File: doc/rgb_led_arbiter.md
# rgb_led_arbiter

Shares the single on-chip RGB LED between several status requesters and generates the three PWM drive signals for the SB_RGBA_DRV primitive (RGB2PWM red, RGB0PWM green, RGB1PWM blue). Fixed-priority arbitration changes ownership only at PWM frame boundaries, so no partial-frame colour glitches reach the LED. Each requester supplies its own colour and can request a blinking display. The block sits between the application status logic and the RGB driver instance at the top level.

## Interface
- NUM_REQ, 4, number of requesters (1..8); index 0 has the highest priority
- PWM_BITS, 8, PWM resolution; one frame is 2^PWM_BITS cycles
- BLINK_CYCLES, 6_000_000, cycles per blink half-period (≥2)
- hw_clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- req  in  NUM_REQ  level request per requester
- color  in  NUM_REQ*3*PWM_BITS  requester i at slice i; within a slice {red, green, blue}, red MSB
- blink  in  NUM_REQ  requester wants blinking display
- gnt  out  NUM_REQ  one-hot current owner, all-zero when idle
- pwm_red / pwm_green / pwm_blue  out  1  registered PWM to RGB2PWM / RGB0PWM / RGB1PWM
- led_en  out  1  high while an owner exists; drives RGBLEDEN and CURREN

## Operation
- Reset: gnt=0, all pwm_*=0, led_en=0, frame counter=0, blink counter=0, blink phase=ON, state IDLE.
- Frame counter cnt is PWM_BITS wide and free-running; it wraps from 2^PWM_BITS-1 to 0.
- States: IDLE (gnt=0) and ACTIVE (one gnt bit set). Arbitration is evaluated only in the cycle where cnt=max:
  - If no req is set, the next state is IDLE.
  - Otherwise the winner is the lowest-index set req, and the next state is ACTIVE with gnt=winner.
- On the boundary edge (cnt max→0):
  - gnt updates.
  - The winner's colour slice and blink bit are latched into duty_r/g/b and blink_l.
  - The latched values are held for the whole frame, so colour and blink changes mid-frame are ignored.
- An owner that drops req mid-frame keeps gnt and its latched colour until the frame ends.
- A higher-priority req arriving mid-frame waits for the boundary; no mid-frame preemption.
- Same owner re-winning: the colour is re-latched, and the blink counter and phase are not disturbed.
- Owner change, or IDLE→ACTIVE: the blink counter is cleared to 0 and the phase set to ON on the boundary edge.
- Blink counter runs only in ACTIVE. When it reaches BLINK_CYCLES-1 it returns to 0 and the phase toggles. The phase takes effect immediately, including mid-frame.
- PWM compare, registered: pwm_x <= ACTIVE && (!blink_l || phase==ON) && (cnt < duty_x).
  - duty 0 gives a constant low.
  - duty 2^PWM_BITS-1 gives a high of (2^PWM_BITS-1)/2^PWM_BITS.
- led_en is registered and equals (state==ACTIVE).
- An asynchronous rst_n assertion mid-frame forces every output to its reset value immediately. After release, arbitration first occurs at cnt=max.

## Timing
- Compare latency is 1 cycle: pwm_x reflects the cnt value of the previous cycle.
- Request-to-grant latency ranges from 1 to 2^PWM_BITS cycles, depending on the frame position.
- gnt and led_en change in the same cycle, on the edge where cnt becomes 0. The first pwm_* high of the new owner appears one cycle later.
- In IDLE all pwm_* outputs are 0 by the cycle after the boundary.

## Configuration
- RGB_ARB_GAMMA_EN defined: the latched duty is (c*c)>>PWM_BITS per channel, computed at the latch edge, with the same timing.
  - Example at PWM_BITS=8: c=255 gives 254, c=128 gives 64, c=15 gives 0.
- Not defined: the latched duty equals c (linear).

## Test plan
All scenarios use PWM_BITS=4, BLINK_CYCLES=64, NUM_REQ=4, with RGB_ARB_GAMMA_EN undefined unless stated.
- Reset/idle: hold rst_n low for 5 cycles, then release with req=0 → gnt=0, led_en=0 and all pwm_*=0 for 100 cycles.
- Single owner: req[2]=1 with color {R=4, G=0, B=15} → gnt=4'b0100 at the next boundary; per frame, pwm_red is high for 4 cycles, pwm_green for 0 and pwm_blue for 15.
- Priority/no preemption: req[2] owns the LED; assert req[0] at cnt=5 → gnt stays 0100 until cnt wraps, then becomes 0001, and the new colour appears from cnt=0.
- Mid-frame colour change and release: change the owner's colour at cnt=3 and drop req at cnt=7 → the old duty completes the frame; IDLE follows at the boundary, and outputs and led_en are 0 afterwards.
- Blink: the owner has blink=1 and R=15 → pwm_red toggles between 64 cycles of PWM and 64 cycles of low. An owner change restarts the phase at ON.
- Gamma build: with RGB_ARB_GAMMA_EN defined, R=15 gives 14 high cycles per frame, R=8 gives 4, and R=3 gives 0.
